// File: rtl/alu_selftest_sequencer.sv
// Self-test sweep for the register-file/ALU datapath: walks every opcode and
// register pair, samples aluResult after a settle window and tallies pass/fail.
module alu_selftest_sequencer #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [REG_WIDTH-1:0]     aluResult,
    output logic [3:0]               aluOpCode,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              passCount,
    output logic [15:0]              errorCount,
    output logic                     failSeen,
    output logic [3:0]               firstFailOp,
    output logic [REG_ADDR_BITS-1:0] firstFailA,
    output logic [REG_ADDR_BITS-1:0] firstFailB,
    output logic [REG_WIDTH-1:0]     firstFailResult
);
    localparam int NUM_OPS = 6;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [2:0]               op_idx, op_idx_nxt;
    logic [SW-1:0]            settle;
    logic [REG_ADDR_BITS-1:0] a_nxt, b_nxt;
    logic [REG_WIDTH-1:0]     opnd_a, opnd_b, expected;
    logic                     sample, last_vec, match;

    function automatic logic [3:0] op_code(input logic [2:0] idx);
        case (idx)
            3'd0:    op_code = 4'b0101;
            3'd1:    op_code = 4'b0110;
            3'd2:    op_code = 4'b1001;
            3'd3:    op_code = 4'b0001;
            3'd4:    op_code = 4'b0010;
            default: op_code = 4'b0011;
        endcase
    endfunction

    // Register file is preloaded with r[i] = i, so operands are just the addresses.
    assign opnd_a = REG_WIDTH'(regAddressA);
    assign opnd_b = REG_WIDTH'(regAddressB);

    always_comb begin
        case (aluOpCode)
            4'b0101, 4'b0110: expected = opnd_a + opnd_b;
            4'b1001:          expected = opnd_a - opnd_b;
            4'b0001:          expected = opnd_a & opnd_b;
            4'b0010:          expected = opnd_a | opnd_b;
            default:          expected = opnd_a ^ opnd_b;
        endcase
    end

    assign match    = (aluResult == expected);
    assign last_vec = (op_idx == 3'(NUM_OPS - 1)) && (&regAddressA) && (&regAddressB);
    assign sample   = (state == RUN) && (settle == '0) && !abort;

    // B is the innermost loop, then A, then opcode.
    always_comb begin
        b_nxt      = regAddressB + 1'b1;
        a_nxt      = regAddressA;
        op_idx_nxt = op_idx;
        if (&regAddressB) begin
            a_nxt = regAddressA + 1'b1;
            if (&regAddressA)
                op_idx_nxt = op_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (sample && last_vec)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_idx          <= '0;
            settle          <= '0;
            aluOpCode       <= '0;
            regAddressA     <= '0;
            regAddressB     <= '0;
            passCount       <= '0;
            errorCount      <= '0;
            failSeen        <= 1'b0;
            firstFailOp     <= '0;
            firstFailA      <= '0;
            firstFailB      <= '0;
            firstFailResult <= '0;
        end else if (state != RUN && start) begin
            op_idx          <= '0;
            settle          <= SETTLE_LOAD;
            aluOpCode       <= op_code(3'd0);
            regAddressA     <= '0;
            regAddressB     <= '0;
            passCount       <= '0;
            errorCount      <= '0;
            failSeen        <= 1'b0;
            firstFailOp     <= '0;
            firstFailA      <= '0;
            firstFailB      <= '0;
            firstFailResult <= '0;
        end else if (state == RUN && abort) begin
            // Results are kept for inspection; only the drive to the cpu is parked.
            op_idx      <= '0;
            settle      <= '0;
            aluOpCode   <= '0;
            regAddressA <= '0;
            regAddressB <= '0;
        end else if (state == RUN) begin
            if (settle != '0) begin
                settle <= settle - 1'b1;
            end else begin
                if (match) begin
                    if (passCount != 16'hFFFF)
                        passCount <= passCount + 16'd1;
                end else begin
                    if (errorCount != 16'hFFFF)
                        errorCount <= errorCount + 16'd1;
                    if (!failSeen) begin
                        failSeen        <= 1'b1;
                        firstFailOp     <= aluOpCode;
                        firstFailA      <= regAddressA;
                        firstFailB      <= regAddressB;
                        firstFailResult <= aluResult;
                    end
                end
                if (!last_vec) begin
                    op_idx      <= op_idx_nxt;
                    aluOpCode   <= op_code(op_idx_nxt);
                    regAddressA <= a_nxt;
                    regAddressB <= b_nxt;
                    settle      <= SETTLE_LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_selftest_sequencer.sv
// Bench for alu_selftest_sequencer: mock ALU datapath, cycle-level behavioural
// model with per-cycle comparison, directed scenarios and randomized runs.
module tb_alu_selftest_sequencer;
    localparam int RW  = 16;
    localparam int RAB = 2;
    localparam int N   = 4;
    localparam int V   = 6 * N * N;
    localparam int S   = 2;
    localparam logic [3:0] OPS [6] = '{4'b0101, 4'b0110, 4'b1001, 4'b0001, 4'b0010, 4'b0011};

    logic clk = 0, reset = 0, start = 0, abort = 0, start1 = 0, abort1 = 0;
    logic [RW-1:0] alu_result, alu_c, alu_q, alu_result1;
    logic [3:0] op, op1, ffop, ffop1;
    logic [RAB-1:0] ra, rb, ffa, ffb, ra1, rb1, ffa1, ffb1;
    logic busy, done, fs, busy1, done1, fs1;
    logic [15:0] pass_cnt, err_cnt, pass1, err1;
    logic [RW-1:0] ffres, ffres1;

    int mode = 0;
    logic bad [256];
    logic [RW-1:0] flip = 16'h0001;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_selftest_sequencer #(.REG_WIDTH(RW), .REG_ADDR_BITS(RAB), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .aluResult(alu_result),
        .aluOpCode(op), .regAddressA(ra), .regAddressB(rb), .busy(busy), .done(done),
        .passCount(pass_cnt), .errorCount(err_cnt), .failSeen(fs), .firstFailOp(ffop),
        .firstFailA(ffa), .firstFailB(ffb), .firstFailResult(ffres));

    alu_selftest_sequencer #(.REG_WIDTH(RW), .REG_ADDR_BITS(RAB), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .aluResult(alu_result1),
        .aluOpCode(op1), .regAddressA(ra1), .regAddressB(rb1), .busy(busy1), .done(done1),
        .passCount(pass1), .errorCount(err1), .failSeen(fs1), .firstFailOp(ffop1),
        .firstFailA(ffa1), .firstFailB(ffb1), .firstFailResult(ffres1));

    // Mock datapath: register file r[i]=i feeding an opcode-decoded ALU.
    function automatic logic [RW-1:0] mock_alu(input logic [3:0] o, input logic [RW-1:0] x, input logic [RW-1:0] y);
        case (o)
            4'b0101, 4'b0110: return x + y;
            4'b1001:          return x - y;
            4'b0001:          return x & y;
            4'b0010:          return x | y;
            4'b0011:          return x ^ y;
            default:          return '0;
        endcase
    endfunction

    always_comb begin
        alu_c = mock_alu(op, RW'(ra), RW'(rb));
        if (mode == 1 && op == 4'b0011) alu_c[0] = 1'b0;
        if (mode == 3 && bad[{op, ra, rb}]) alu_c = alu_c ^ flip;
    end
    always_ff @(posedge clk) alu_q <= alu_c;
    assign alu_result = (mode == 2) ? alu_q : alu_c;
    always_ff @(posedge clk) alu_result1 <= mock_alu(op1, RW'(ra1), RW'(rb1));

    // Reference: vector index i -> opcode index i/(N*N), A=(i/N)%N, B=i%N.
    function automatic logic [RW-1:0] model_exp(input int idx);
        int oi, a, b, r;
        oi = idx / (N * N); a = (idx / N) % N; b = idx % N;
        case (oi)
            0, 1:    r = a + b;
            2:       r = a - b;
            3:       r = a & b;
            4:       r = a | b;
            default: r = a ^ b;
        endcase
        return RW'(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Inputs as seen by the DUT on the most recent rising edge.
    logic s_start, s_abort, s_rst = 1'b1;
    logic [RW-1:0] s_res;
    always @(posedge clk) begin
        s_start <= start; s_abort <= abort; s_res <= alu_result; s_rst <= reset;
    end

    int m_state = 0, m_t = 0, m_vec = 0, m_pass = 0, m_err = 0;
    logic m_fs = 0;
    logic [3:0] m_fop = 0;
    int m_fa = 0, m_fb = 0;
    logic [RW-1:0] m_fres = 0, seen_add33 = 0, seen_sub01 = 0;

    task automatic model_reset();
        m_state = 0; m_t = 0; m_vec = 0; m_pass = 0; m_err = 0;
        m_fs = 0; m_fop = 0; m_fa = 0; m_fb = 0; m_fres = 0;
    endtask

    task automatic model_step();
        int idx;
        if (m_state == 1) begin
            if (s_abort) begin
                m_state = 0; m_vec = 0;
            end else begin
                m_t++;
                if (m_t % S == 0) begin
                    idx = m_t / S - 1;
                    if (idx == 3 * N + 3) seen_add33 = s_res;
                    if (idx == 2 * N * N + 1) seen_sub01 = s_res;
                    if (s_res == model_exp(idx)) m_pass++;
                    else begin
                        m_err++;
                        if (!m_fs) begin
                            m_fs = 1; m_fop = OPS[idx / (N * N)];
                            m_fa = (idx / N) % N; m_fb = idx % N; m_fres = s_res;
                        end
                    end
                    if (idx == V - 1) m_state = 2;
                end
                if (m_state == 1) m_vec = m_t / S;
            end
        end else if (s_start) begin
            model_reset();
            m_state = 1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset || s_rst) model_reset();
        else model_step();
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 2));
        chk("opcode", 32'(op), (m_state == 0) ? 0 : 32'(OPS[m_vec / (N * N)]));
        chk("addr_a", 32'(ra), (m_state == 0) ? 0 : 32'((m_vec / N) % N));
        chk("addr_b", 32'(rb), (m_state == 0) ? 0 : 32'(m_vec % N));
        chk("pass_count", 32'(pass_cnt), 32'(m_pass));
        chk("error_count", 32'(err_cnt), 32'(m_err));
        chk("fail_seen", 32'(fs), 32'(m_fs));
        chk("first_op", 32'(ffop), 32'(m_fop));
        chk("first_a", 32'(ffa), 32'(m_fa));
        chk("first_b", 32'(ffb), 32'(m_fb));
        chk("first_result", 32'(ffres), 32'(m_fres));
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic run_main(output int n);
        start = 1; tick(); start = 0;
        n = 0;
        while (!done && n < 5000) begin tick(); n++; end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_outs"}, 32'({op, ra, rb}), 0);
    endtask

    initial begin
        int n;
        foreach (bad[i]) bad[i] = 1'b0;
        #1 reset = 1;
        #2;
        chk_idle_zero("reset");
        chk("reset_counts", 32'({pass_cnt, err_cnt}), 0);
        chk("reset_fail", 32'({fs, ffop, ffa, ffb, ffres}), 0);
        tick(); tick(); reset = 0; tick();

        // Clean ALU.
        mode = 0; run_main(n);
        chk("clean_latency", 32'(n), 192);
        chk("clean_pass", 32'(pass_cnt), 96);
        chk("clean_err", 32'(err_cnt), 0);
        chk("clean_failseen", 32'(fs), 0);

        // XOR with result bit0 stuck low.
        mode = 1; run_main(n);
        chk("xor_err", 32'(err_cnt), 8);
        chk("xor_pass", 32'(pass_cnt), 88);
        chk("xor_first_op", 32'(ffop), 32'(4'b0011));
        chk("xor_first_ab", 32'({ffa, ffb}), 32'({2'd0, 2'd1}));
        chk("xor_first_res", 32'(ffres), 0);
        chk("xor_failseen", 32'(fs), 1);

        // One register stage, settle 2.
        mode = 2; run_main(n);
        chk("reg_s2_err", 32'(err_cnt), 0);
        chk("reg_s2_add33", 32'(seen_add33), 6);
        chk("reg_s2_sub01", 32'(seen_sub01), 32'h0000FFFF);

        // One register stage, settle 1.
        start1 = 1; tick(); start1 = 0;
        n = 0;
        while (!done1 && n < 5000) begin tick(); n++; end
        chk("reg_s1_latency", 32'(n), 96);
        chk("reg_s1_err_nonzero", 32'(err1 != 0), 1);

        // Abort at cycle 50.
        mode = 0;
        start = 1; tick(); start = 0;
        repeat (49) tick();
        abort = 1; tick(); abort = 0;
        chk_idle_zero("abort");
        chk("abort_pass", 32'(pass_cnt), 24);
        chk("abort_err", 32'(err_cnt), 0);
        run_main(n);
        chk("after_abort_latency", 32'(n), 192);
        chk("after_abort_pass", 32'(pass_cnt), 96);

        // Start while busy, then reset mid-run.
        start = 1; tick(); start = 0;
        repeat (30) tick();
        start = 1; tick(); start = 0;
        chk("restart_ignored_busy", 32'(busy), 1);
        repeat (20) tick();
        reset = 1; #1;
        chk_idle_zero("midreset");
        chk("midreset_counts", 32'({pass_cnt, err_cnt}), 0);
        tick(); tick(); reset = 0; tick();
        run_main(n);
        chk("post_reset_latency", 32'(n), 192);
        chk("post_reset_pass", 32'(pass_cnt), 96);
        chk("post_reset_err", 32'(err_cnt), 0);

        // Randomized runs: fault patterns, stray starts and occasional aborts.
        repeat (8) begin
            mode = $urandom_range(0, 3);
            foreach (bad[i]) bad[i] = ($urandom_range(0, 7) == 0);
            flip = RW'($urandom_range(1, 65535));
            start = 1; tick(); start = 0;
            n = 0;
            while (busy && n < 1000) begin
                start = ($urandom_range(0, 19) == 0);
                abort = ($urandom_range(0, 249) == 0);
                tick(); n++;
                start = 0; abort = 0;
            end
            chk("random_run_ends", 32'(busy), 0);
            repeat ($urandom_range(1, 4)) tick();
        end

        tick();
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end
endmodule
